basket_controller: RTL and testbench
====================================

Name: basket_controller

Overview:
- Responder end of the sale-terminal state machine's basket command interface.
- Consumes single-cycle add, cancel and clear pulses together with a product ID and quantity.
- Maintains a compacted list of distinct basket entries (ID, quantity) and reports the entry count back to the state machine.
- Exposes a combinational read port for display logic.

Parameters:
- MAX_ITEMS, 8, number of basket slots (1..15, so the count fits 4 bits).
- QTY_W, 5, per-entry quantity width; quantities saturate at 2^QTY_W-1.

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- Enable_Pulse  in  1  one-cycle "add ProductID x ProductQuantity".
- Cancel_Pulse  in  1  one-cycle "remove entry ProductID".
- RSTN_Pulse  in  1  one-cycle active-low synchronous basket clear.
- ProductID  in  4  command product ID; 4'hF means invalid.
- ProductQuantity  in  4  add quantity, 1..4.
- BasketProductNum  out  4  number of occupied entries.
- Busy  out  1  high while a command is in progress.
- Done  out  1  one-cycle pulse when a command completes.
- Err  out  2  status of the last command: 0 ok, 1 full, 2 not found, 3 invalid.
- Rd_Index  in  4  read slot select.
- Rd_ProductID  out  4  ID stored at Rd_Index.
- Rd_Quantity  out  QTY_W  quantity stored at Rd_Index.
- Rd_Valid  out  1  Rd_Index < BasketProductNum.
- Total_Price  out  12  running basket total (see Optional Feature).

Behaviour:
- Reset (RESET_N low, asynchronous):
  - State S_IDLE; count 0; all slots ID 4'hF, qty 0.
  - Busy 0, Done 0, Err 0, Total_Price 0.
- RSTN_Pulse low: same clear as reset, applied synchronously on that edge.
  - Overrides any Enable/Cancel in the same cycle.
  - Aborts an in-flight command; no Done is issued.
- Command acceptance in S_IDLE only:
  - Cancel_Pulse has priority over Enable_Pulse when both arrive together.
  - Command ID and quantity are latched on acceptance; Busy rises the next cycle.
- Invalid command (ID 4'hF, or add with quantity 0): go straight to S_DONE with Err=3; basket unchanged.
- Pulses arriving while Busy are dropped silently. Bench-visible effect: no state change.
- States: S_IDLE, S_SCAN, S_UPDATE, S_SHIFT, S_DONE.
- S_SCAN: scan_idx starts at 0, one slot per cycle.
  - scan_idx==count: not found, go to S_UPDATE.
  - slot ID matches: found at scan_idx, go to S_UPDATE.
  - otherwise scan_idx+1.
- S_UPDATE, add:
  - Found: qty = min(qty + ProductQuantity, 2^QTY_W-1); Err 0.
  - Not found and count<MAX_ITEMS: write the entry at slot[count]; count+1; Err 0.
  - Not found and count==MAX_ITEMS: Err 1; basket unchanged.
- S_UPDATE, cancel:
  - Not found: Err 2.
  - Found: go to S_SHIFT with i = found index.
- S_SHIFT: each cycle slot[i] <= slot[i+1] and i+1, while i < count-1.
  - On exit, the last slot is cleared to 4'hF/0 and count-1.
  - Err 0. Cancelling the last slot takes 0 shift cycles.
- S_DONE: Done=1 for one cycle, Busy=0, return to S_IDLE.
  - Err holds until the next accepted command.
- Latency, accept edge to Done pulse: (k+1) scan cycles + 1 update cycle + s shift cycles + 1 done cycle.
  - k = match index, or count when not found.
  - Empty-basket add: Done 3 cycles after accept.
- Read port is purely combinational from the slot registers.
  - Rd_Index >= count gives Rd_Valid 0 and returns the cleared slot value.
  - Rd_Index >= MAX_ITEMS gives ID 4'hF, qty 0.
- BasketProductNum is registered and equals count.

Optional Feature:
- Macro BASKET_TOTAL_EN.
- Defined:
  - Total_Price is maintained incrementally.
  - Add: += (applied qty delta) x price(ID). After saturation the applied delta may be less than ProductQuantity.
  - Cancel: -= entry qty x price(ID), computed in S_UPDATE.
  - Clear sets Total_Price to 0.
  - Arithmetic saturates at 12'hFFF and never goes below 0.
- Undefined: Total_Price is tied to 0, and no price logic or multiplier is built.

Decomposition:
- Shared package sale_terminal_pkg holds:
  - The state encodings.
  - The Err codes (ERR_OK, ERR_FULL, ERR_NOTFOUND, ERR_INVALID).
  - INVALID_ID = 4'hF.
  - The product price table function price_of(id), which is also usable by the display logic.
- One natural sub-module: basket_slot_array, the slot registers with a combinational read mux and shift/write controls.
- The FSM, scan logic and optional total stay in basket_controller.

Test Plan:
- Reset, then Enable with ID 3, qty 2 -> Done 3 cycles later; count 1; Rd_Index 0 gives ID 3, qty 2, Rd_Valid 1; Err 0.
- Adds of IDs 1, 2, 3 (qty 1), then Cancel ID 1 -> 2 shift cycles; count 2; slots [2, 3]; slot 2 reads 4'hF/0.
- Add ID 5 qty 4 eight times with QTY_W=5 -> qty saturates at 31, not 32; count stays 1.
- Fill 8 distinct IDs, then add ID 9 -> Err 1, count 8. Cancel ID 12 (absent) -> Err 2.
- Enable and Cancel in the same cycle for ID 2, already present -> cancel performed. A pulse arriving while Busy -> dropped. RSTN_Pulse mid-shift -> count 0, no Done.
- With BASKET_TOTAL_EN: add ID 1 qty 3, then cancel ID 1 -> Total_Price is 3 x price_of(1), then 0.

Source files
------------

// File: rtl/sale_terminal_pkg.sv
// Shared definitions for the sale-terminal: FSM states, status codes,
// the invalid product marker and the product price table.
package sale_terminal_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_UPDATE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_FULL     = 2'd1;
  localparam logic [1:0] ERR_NOTFOUND = 2'd2;
  localparam logic [1:0] ERR_INVALID  = 2'd3;

  localparam logic [3:0] INVALID_ID = 4'hF;

  // Unit price per product ID; the invalid ID has no price.
  function automatic logic [7:0] price_of(input logic [3:0] id);
    case (id)
      4'd0:    price_of = 8'd12;
      4'd1:    price_of = 8'd25;
      4'd2:    price_of = 8'd8;
      4'd3:    price_of = 8'd40;
      4'd4:    price_of = 8'd15;
      4'd5:    price_of = 8'd30;
      4'd6:    price_of = 8'd5;
      4'd7:    price_of = 8'd60;
      4'd8:    price_of = 8'd22;
      4'd9:    price_of = 8'd18;
      4'd10:   price_of = 8'd35;
      4'd11:   price_of = 8'd9;
      4'd12:   price_of = 8'd50;
      4'd13:   price_of = 8'd14;
      4'd14:   price_of = 8'd27;
      default: price_of = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/basket_slot_array.sv
// Basket slot registers: one (ID, qty) pair per slot, a write port, a
// one-slot shift-down move, and two combinational read ports (display, scan).
module basket_slot_array
  import sale_terminal_pkg::*;
#(
  parameter int MAX_ITEMS = 8,
  parameter int QTY_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_all,
  input  logic             wr_en,
  input  logic [3:0]       wr_idx,
  input  logic [3:0]       wr_id,
  input  logic [QTY_W-1:0] wr_qty,
  input  logic             shift_en,
  input  logic [3:0]       shift_idx,
  input  logic [3:0]       rd_idx,
  output logic [3:0]       rd_id,
  output logic [QTY_W-1:0] rd_qty,
  input  logic [3:0]       scan_idx,
  output logic [3:0]       scan_id,
  output logic [QTY_W-1:0] scan_qty
);

  logic [3:0]       slot_id  [MAX_ITEMS];
  logic [QTY_W-1:0] slot_qty [MAX_ITEMS];

  generate
    for (genvar gi = 0; gi < MAX_ITEMS; gi++) begin : g_slot
      logic [3:0]       id_reg;
      logic [QTY_W-1:0] qty_reg;
      logic [3:0]       src_id;
      logic [QTY_W-1:0] src_qty;

      // The top slot has no upper neighbour, so a shift into it empties it.
      if (gi < MAX_ITEMS - 1) begin : g_src
        assign src_id  = slot_id[gi+1];
        assign src_qty = slot_qty[gi+1];
      end else begin : g_last
        assign src_id  = INVALID_ID;
        assign src_qty = '0;
      end

      // Slot update: clear beats write beats shift-down.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          id_reg  <= INVALID_ID;
          qty_reg <= '0;
        end else if (clear_all) begin
          id_reg  <= INVALID_ID;
          qty_reg <= '0;
        end else if (wr_en && wr_idx == 4'(gi)) begin
          id_reg  <= wr_id;
          qty_reg <= wr_qty;
        end else if (shift_en && shift_idx == 4'(gi)) begin
          id_reg  <= src_id;
          qty_reg <= src_qty;
        end
      end

      assign slot_id[gi]  = id_reg;
      assign slot_qty[gi] = qty_reg;
    end
  endgenerate

  // Read muxes; indices past the last slot read as an empty slot.
  always_comb begin
    rd_id    = INVALID_ID;
    rd_qty   = '0;
    scan_id  = INVALID_ID;
    scan_qty = '0;
    for (int i = 0; i < MAX_ITEMS; i++) begin
      if (rd_idx == 4'(i)) begin
        rd_id  = slot_id[i];
        rd_qty = slot_qty[i];
      end
      if (scan_idx == 4'(i)) begin
        scan_id  = slot_id[i];
        scan_qty = slot_qty[i];
      end
    end
  end

endmodule

// File: rtl/basket_controller.sv
// Basket command responder: add/cancel/clear on a compacted list of
// distinct (ID, qty) entries. Optional running total with BASKET_TOTAL_EN.
module basket_controller
  import sale_terminal_pkg::*;
#(
  parameter int MAX_ITEMS = 8,
  parameter int QTY_W     = 5
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             Enable_Pulse,
  input  logic             Cancel_Pulse,
  input  logic             RSTN_Pulse,
  input  logic [3:0]       ProductID,
  input  logic [3:0]       ProductQuantity,
  output logic [3:0]       BasketProductNum,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       Err,
  input  logic [3:0]       Rd_Index,
  output logic [3:0]       Rd_ProductID,
  output logic [QTY_W-1:0] Rd_Quantity,
  output logic             Rd_Valid,
  output logic [11:0]      Total_Price
);

  localparam logic [3:0]       MAX_CNT = 4'(MAX_ITEMS);
  localparam logic [QTY_W-1:0] QTY_MAX = '1;
  localparam int               SUM_W   = QTY_W + 1;

  state_t           state_reg, state_next;
  logic [3:0]       scan_idx_reg, scan_idx_next;
  logic [3:0]       count_reg, count_next;
  logic             found_reg, found_next;
  logic             cmd_cancel_reg, cmd_cancel_next;
  logic [3:0]       cmd_id_reg, cmd_id_next;
  logic [3:0]       cmd_qty_reg, cmd_qty_next;
  logic [1:0]       err_reg, err_next;

  logic             clear_all, wr_en, shift_en;
  logic [3:0]       wr_idx, wr_id;
  logic [QTY_W-1:0] wr_qty;
  logic [3:0]       scan_id;
  logic [QTY_W-1:0] scan_qty, base_qty, sat_qty;
  logic [SUM_W-1:0] qty_sum;

  basket_slot_array #(
    .MAX_ITEMS(MAX_ITEMS),
    .QTY_W    (QTY_W)
  ) u_slots (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .clear_all(clear_all),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_id    (wr_id),
    .wr_qty   (wr_qty),
    .shift_en (shift_en),
    .shift_idx(scan_idx_reg),
    .rd_idx   (Rd_Index),
    .rd_id    (Rd_ProductID),
    .rd_qty   (Rd_Quantity),
    .scan_idx (scan_idx_reg),
    .scan_id  (scan_id),
    .scan_qty (scan_qty)
  );

  // Saturating add quantity; a new entry starts from zero.
  always_comb begin
    base_qty = found_reg ? scan_qty : '0;
    qty_sum  = {1'b0, base_qty} + SUM_W'(cmd_qty_reg);
    sat_qty  = (qty_sum > {1'b0, QTY_MAX}) ? QTY_MAX : qty_sum[QTY_W-1:0];
  end

  // FSM state and command registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= S_IDLE;
      scan_idx_reg   <= '0;
      count_reg      <= '0;
      found_reg      <= 1'b0;
      cmd_cancel_reg <= 1'b0;
      cmd_id_reg     <= INVALID_ID;
      cmd_qty_reg    <= '0;
      err_reg        <= ERR_OK;
    end else begin
      state_reg      <= state_next;
      scan_idx_reg   <= scan_idx_next;
      count_reg      <= count_next;
      found_reg      <= found_next;
      cmd_cancel_reg <= cmd_cancel_next;
      cmd_id_reg     <= cmd_id_next;
      cmd_qty_reg    <= cmd_qty_next;
      err_reg        <= err_next;
    end
  end

  // Next-state, scan/update/shift decisions and slot-array controls.
  always_comb begin
    state_next      = state_reg;
    scan_idx_next   = scan_idx_reg;
    count_next      = count_reg;
    found_next      = found_reg;
    cmd_cancel_next = cmd_cancel_reg;
    cmd_id_next     = cmd_id_reg;
    cmd_qty_next    = cmd_qty_reg;
    err_next        = err_reg;
    clear_all       = 1'b0;
    wr_en           = 1'b0;
    wr_idx          = '0;
    wr_id           = INVALID_ID;
    wr_qty          = '0;
    shift_en        = 1'b0;

    if (!RSTN_Pulse) begin
      // Clear wins over everything, including a command in flight.
      clear_all     = 1'b1;
      state_next    = S_IDLE;
      scan_idx_next = '0;
      count_next    = '0;
      found_next    = 1'b0;
      err_next      = ERR_OK;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (Cancel_Pulse || Enable_Pulse) begin
            cmd_cancel_next = Cancel_Pulse;
            cmd_id_next     = ProductID;
            cmd_qty_next    = ProductQuantity;
            scan_idx_next   = '0;
            found_next      = 1'b0;
            if (ProductID == INVALID_ID ||
                (!Cancel_Pulse && ProductQuantity == 4'd0)) begin
              err_next   = ERR_INVALID;
              state_next = S_DONE;
            end else begin
              state_next = S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (scan_idx_reg == count_reg) begin
            found_next = 1'b0;
            state_next = S_UPDATE;
          end else if (scan_id == cmd_id_reg) begin
            found_next = 1'b1;
            state_next = S_UPDATE;
          end else begin
            scan_idx_next = scan_idx_reg + 4'd1;
          end
        end
        S_UPDATE: begin
          state_next = S_DONE;
          if (cmd_cancel_reg) begin
            if (!found_reg) begin
              err_next = ERR_NOTFOUND;
            end else if (scan_idx_reg == count_reg - 4'd1) begin
              // Last entry: nothing to compact, just empty it.
              wr_en      = 1'b1;
              wr_idx     = scan_idx_reg;
              count_next = count_reg - 4'd1;
              err_next   = ERR_OK;
            end else begin
              state_next = S_SHIFT;
            end
          end else if (found_reg) begin
            wr_en    = 1'b1;
            wr_idx   = scan_idx_reg;
            wr_id    = cmd_id_reg;
            wr_qty   = sat_qty;
            err_next = ERR_OK;
          end else if (count_reg < MAX_CNT) begin
            wr_en      = 1'b1;
            wr_idx     = count_reg;
            wr_id      = cmd_id_reg;
            wr_qty     = sat_qty;
            count_next = count_reg + 4'd1;
            err_next   = ERR_OK;
          end else begin
            err_next = ERR_FULL;
          end
        end
        S_SHIFT: begin
          shift_en = 1'b1;
          if (scan_idx_reg + 4'd1 == count_reg - 4'd1) begin
            // Final move also empties the vacated top entry.
            wr_en      = 1'b1;
            wr_idx     = count_reg - 4'd1;
            count_next = count_reg - 4'd1;
            err_next   = ERR_OK;
            state_next = S_DONE;
          end else begin
            scan_idx_next = scan_idx_reg + 4'd1;
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  assign Busy             = (state_reg == S_SCAN) || (state_reg == S_UPDATE) ||
                            (state_reg == S_SHIFT);
  assign Done             = (state_reg == S_DONE);
  assign Err              = err_reg;
  assign BasketProductNum = count_reg;
  assign Rd_Valid         = (Rd_Index < count_reg);

`ifdef BASKET_TOTAL_EN
  logic [11:0]      total_reg, total_next;
  logic [QTY_W-1:0] delta_qty;
  logic [23:0]      delta_price, total_ext, total_sum;

  // Running total: add the applied quantity delta, or subtract a cancelled entry.
  always_comb begin
    total_next  = total_reg;
    delta_qty   = cmd_cancel_reg ? scan_qty : (sat_qty - base_qty);
    delta_price = 24'(delta_qty) * 24'(price_of(cmd_id_reg));
    total_ext   = 24'(total_reg);
    total_sum   = total_ext + delta_price;
    if (!RSTN_Pulse) begin
      total_next = '0;
    end else if (state_reg == S_UPDATE && cmd_cancel_reg && found_reg) begin
      total_next = (delta_price > total_ext) ? 12'd0 : 12'(total_ext - delta_price);
    end else if (state_reg == S_UPDATE && !cmd_cancel_reg && wr_en) begin
      total_next = (total_sum > 24'hFFF) ? 12'hFFF : total_sum[11:0];
    end
  end

  // Total register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) total_reg <= '0;
    else          total_reg <= total_next;
  end

  assign Total_Price = total_reg;
`else
  assign Total_Price = '0;
`endif

endmodule

// File: tb/tb_basket_controller.sv
// Randomized scoreboard bench for basket_controller. The reference model keeps
// the basket as a pair of queues; a monitor checks every Done pulse.
`timescale 1ns/100ps
module tb_basket_controller;
  import sale_terminal_pkg::*;

  localparam int MAXI = 8;
  localparam int QW   = 5;
  localparam int QMAX = 31;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N = 1'b0;
  logic          Enable_Pulse = 1'b0;
  logic          Cancel_Pulse = 1'b0;
  logic          RSTN_Pulse = 1'b1;
  logic [3:0]    ProductID = 4'd0;
  logic [3:0]    ProductQuantity = 4'd0;
  logic [3:0]    Rd_Index = 4'd0;
  logic [3:0]    BasketProductNum;
  logic          Busy, Done, Rd_Valid;
  logic [1:0]    Err;
  logic [3:0]    Rd_ProductID;
  logic [QW-1:0] Rd_Quantity;
  logic [11:0]   Total_Price;

  basket_controller #(.MAX_ITEMS(MAXI), .QTY_W(QW)) dut (
    .CLOCK_50        (CLOCK_50),
    .RESET_N         (RESET_N),
    .Enable_Pulse    (Enable_Pulse),
    .Cancel_Pulse    (Cancel_Pulse),
    .RSTN_Pulse      (RSTN_Pulse),
    .ProductID       (ProductID),
    .ProductQuantity (ProductQuantity),
    .BasketProductNum(BasketProductNum),
    .Busy            (Busy),
    .Done            (Done),
    .Err             (Err),
    .Rd_Index        (Rd_Index),
    .Rd_ProductID    (Rd_ProductID),
    .Rd_Quantity     (Rd_Quantity),
    .Rd_Valid        (Rd_Valid),
    .Total_Price     (Total_Price)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int              err;
    int              cnt;
    int              lat;
    int              issue;
    int              total;
    logic [15:0][3:0] ids;
    logic [15:0][7:0] qtys;
  } exp_t;

  exp_t sb[$];
  int   m_id[$];
  int   m_qty[$];
  int   m_total = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  int   txn = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int unit_price(input int id);
`ifdef BASKET_TOTAL_EN
    return int'(price_of(4'(id)));
`else
    return 0;
`endif
  endfunction

  // Reference model: apply one command to the queue basket, return expectations.
  function automatic exp_t predict(input bit can, input int id, input int qty);
    exp_t e;
    int   idx = -1;
    int   k, nq;
    for (int i = 0; i < m_id.size(); i++)
      if (idx < 0 && m_id[i] == id) idx = i;
    k = (idx < 0) ? m_id.size() : idx;
    e.issue = cyc;
    if (id == 15 || (!can && qty == 0)) begin
      e.err = 3;
      e.lat = 1;
    end else if (can) begin
      if (idx < 0) begin
        e.err = 2;
        e.lat = k + 3;
      end else begin
        e.err = 0;
        e.lat = k + 3 + (m_id.size() - 1 - idx);
        m_total = m_total - m_qty[idx] * unit_price(id);
        if (m_total < 0) m_total = 0;
        m_id.delete(idx);
        m_qty.delete(idx);
      end
    end else begin
      e.lat = k + 3;
      e.err = 0;
      if (idx >= 0) begin
        nq = (m_qty[idx] + qty > QMAX) ? QMAX : m_qty[idx] + qty;
        m_total = m_total + (nq - m_qty[idx]) * unit_price(id);
        m_qty[idx] = nq;
      end else if (m_id.size() < MAXI) begin
        m_id.push_back(id);
        m_qty.push_back(qty);
        m_total = m_total + qty * unit_price(id);
      end else begin
        e.err = 1;
      end
      if (m_total > 4095) m_total = 4095;
    end
    e.cnt   = m_id.size();
    e.total = m_total;
    for (int i = 0; i < 16; i++) begin
      e.ids[i]  = (i < m_id.size()) ? 4'(m_id[i]) : 4'hF;
      e.qtys[i] = (i < m_id.size()) ? 8'(m_qty[i]) : 8'd0;
    end
    return e;
  endfunction

  // Monitor: every Done pulse pops one expectation and checks the whole basket.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (RESET_N && Done) begin
        done_count++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          txn++;
          chk("latency", cyc - e.issue, e.lat);
          chk("err", int'(Err), e.err);
          chk("count", int'(BasketProductNum), e.cnt);
          chk("total", int'(Total_Price), e.total);
          for (int i = 0; i < 16; i++) begin
            Rd_Index = 4'(i);
            #0.2;
            chk($sformatf("rd_id[%0d]", i), int'(Rd_ProductID), int'(e.ids[i]));
            chk($sformatf("rd_qty[%0d]", i), int'(Rd_Quantity), int'(e.qtys[i]));
            chk($sformatf("rd_valid[%0d]", i), int'(Rd_Valid), (i < e.cnt) ? 1 : 0);
          end
          $display("txn %0d: err=%0d count=%0d latency=%0d total=%0d",
                   txn, Err, BasketProductNum, cyc - e.issue, Total_Price);
        end
      end
    end
  end

  // Issue one command at a negedge and wait (bounded) for its Done.
  task automatic issue(input bit en, input bit can, input int id, input int qty,
                       input bit inject);
    exp_t e;
    bit   invalid;
    int   n;
    invalid = (id == 15) || (!can && qty == 0);
    e = predict(can, id, qty);
    sb.push_back(e);
    Enable_Pulse    = en;
    Cancel_Pulse    = can;
    ProductID       = 4'(id);
    ProductQuantity = 4'(qty);
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b0;
    Cancel_Pulse = 1'b0;
    chk("busy_after_accept", int'(Busy), invalid ? 0 : 1);
    if (inject) begin
      // A pulse while the command is in flight must be ignored.
      Enable_Pulse    = 1'b1;
      ProductID       = 4'($urandom_range(0, 14));
      ProductQuantity = 4'($urandom_range(1, 4));
    end
    n = 0;
    while (!Done && n < 200) begin
      @(negedge CLOCK_50);
      Enable_Pulse = 1'b0;
      n++;
    end
    if (!Done) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b0;
  endtask

  task automatic clear_basket();
    RSTN_Pulse = 1'b0;
    @(negedge CLOCK_50);
    RSTN_Pulse = 1'b1;
    m_id.delete();
    m_qty.delete();
    m_total = 0;
    chk("clear_count", int'(BasketProductNum), 0);
    chk("clear_total", int'(Total_Price), 0);
  endtask

  initial begin
    int r, id, qty, dc;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_count", int'(BasketProductNum), 0);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_done", int'(Done), 0);
    chk("reset_err", int'(Err), 0);
    chk("reset_total", int'(Total_Price), 0);
    chk("reset_rd_valid", int'(Rd_Valid), 0);
    chk("reset_rd_id", int'(Rd_ProductID), 15);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);

    // First add into an empty basket.
    issue(1, 0, 3, 2, 0);
    clear_basket();
    // Three adds, then cancel the first entry (two shift cycles).
    issue(1, 0, 1, 1, 0);
    issue(1, 0, 2, 1, 0);
    issue(1, 0, 3, 1, 0);
    issue(0, 1, 1, 0, 0);
    clear_basket();
    // Quantity saturation.
    repeat (8) issue(1, 0, 5, 4, 0);
    clear_basket();
    // Fill, overflow, cancel of an absent ID.
    for (int i = 0; i < MAXI; i++) issue(1, 0, i, 1, 0);
    issue(1, 0, 9, 1, 0);
    issue(0, 1, 12, 0, 0);
    clear_basket();
    // Simultaneous enable and cancel, dropped pulse, invalid commands.
    issue(1, 0, 2, 1, 0);
    issue(1, 1, 2, 3, 0);
    issue(1, 0, 4, 2, 1);
    issue(1, 0, 15, 2, 0);
    issue(1, 0, 6, 0, 1);
    issue(0, 1, 15, 0, 0);
    clear_basket();
    // Running total add then cancel.
    issue(1, 0, 1, 3, 0);
    issue(0, 1, 1, 0, 0);

    // Clear in the middle of a shift aborts without Done.
    clear_basket();
    for (int i = 1; i <= 4; i++) issue(1, 0, i, 2, 0);
    Cancel_Pulse = 1'b1;
    ProductID    = 4'd1;
    @(negedge CLOCK_50);
    Cancel_Pulse = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    chk("abort_busy_mid_shift", int'(Busy), 1);
    dc = done_count;
    clear_basket();
    repeat (10) @(negedge CLOCK_50);
    chk("abort_no_done", done_count, dc);
    chk("abort_count", int'(BasketProductNum), 0);
    chk("abort_busy", int'(Busy), 0);

    // Randomized traffic.
    for (int t = 0; t < 250; t++) begin
      r   = $urandom_range(0, 99);
      id  = ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 10);
      qty = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
      if (r < 60)      issue(1, 0, id, qty, $urandom_range(0, 9) == 0);
      else if (r < 88) issue(0, 1, id, qty, $urandom_range(0, 9) == 0);
      else if (r < 95) issue(1, 1, id, qty, 0);
      else             clear_basket();
    end

    repeat (5) @(negedge CLOCK_50);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
